// File: rtl/soc_system_signal_sampler_pkg.sv
// Shared register map, CONTROL/STATUS bit positions and divider width
// for the periodic signal sampler.
package soc_system_signal_sampler_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_DIVIDER = 2'd3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  localparam int STAT_LEVEL_W  = 7;
  localparam int STAT_EMPTY    = 8;
  localparam int STAT_FULL     = 9;
  localparam int STAT_OVERFLOW = 10;

  localparam int DIV_W = 16;

endpackage

// File: rtl/soc_system_signal_fifo.sv
// Sample FIFO: push/pop/flush with a first-word-fall-through head output.
// Flush wins over push; push into a full FIFO succeeds only alongside a pop.
module soc_system_signal_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify requests against occupancy; a pop frees the slot for a same-cycle push.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && !flush && (!full || do_pop_s);
  end

  assign full  = (level_r == LW'(DEPTH));
  assign empty = (level_r == {LW{1'b0}});
  assign level = level_r;
  assign rdata = mem[rd_ptr_r];

  // Storage is not reset; the level counter masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/soc_system_signal_sampler.sv
// Avalon-MM signal sampler: captures in_port every D+1 cycles into a FIFO
// and exposes DATA/STATUS/CONTROL/DIVIDER registers plus a non-empty irq.
module soc_system_signal_sampler #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    address,
  input  logic          read,
  input  logic          write,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  input  logic [DW-1:0] in_port,
  output logic          irq
);
  import soc_system_signal_sampler_pkg::*;

  localparam int LW = $clog2(DEPTH + 1);

  logic             enable_r;
  logic             irq_en_r;
  logic             overflow_r;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] cnt_r;
  logic [DW-1:0]    readdata_r;
  logic             irq_r;

  logic [DW-1:0] fifo_data_s;
  logic [LW-1:0] fifo_level_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          ctrl_wr_s;
  logic          div_wr_s;
  logic          flush_s;
  logic          sample_s;
  logic          pop_s;
  logic [DW-1:0] rd_mux_s;
  logic          unused_s;

  assign unused_s = ^writedata[DW-1:DIV_W];

  // Decode bus strobes and the sample tick.
  always_comb begin
    ctrl_wr_s = write && (address == ADDR_CONTROL);
    div_wr_s  = write && (address == ADDR_DIVIDER);
    flush_s   = ctrl_wr_s && writedata[CTRL_FLUSH];
    sample_s  = enable_r && (cnt_r == div_r);
    pop_s     = read && (address == ADDR_DATA);
  end

  soc_system_signal_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (sample_s),
    .pop   (pop_s),
    .flush (flush_s),
    .wdata (in_port),
    .rdata (fifo_data_s),
    .level (fifo_level_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Read mux reflects pre-edge state, so a flushing cycle still sees the old head.
  always_comb begin
    rd_mux_s = {DW{1'b0}};
    case (address)
      ADDR_DATA: begin
        if (!fifo_empty_s) rd_mux_s = fifo_data_s;
        else               rd_mux_s = {DW{1'b0}};
      end
      ADDR_STATUS: begin
        rd_mux_s[STAT_LEVEL_W-1:0] = STAT_LEVEL_W'(fifo_level_s);
        rd_mux_s[STAT_EMPTY]       = fifo_empty_s;
        rd_mux_s[STAT_FULL]        = fifo_full_s;
        rd_mux_s[STAT_OVERFLOW]    = overflow_r;
      end
      ADDR_CONTROL: begin
        rd_mux_s[CTRL_ENABLE] = enable_r;
        rd_mux_s[CTRL_IRQ_EN] = irq_en_r;
      end
      ADDR_DIVIDER: rd_mux_s[DIV_W-1:0] = div_r;
      default:      rd_mux_s = {DW{1'b0}};
    endcase
  end

  // Divider counter: held at 0 while disabled, restarted by any DIVIDER write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt_r <= {DIV_W{1'b0}};
    else if (div_wr_s)         cnt_r <= {DIV_W{1'b0}};
    else if (!enable_r)        cnt_r <= {DIV_W{1'b0}};
    else if (cnt_r == div_r)   cnt_r <= {DIV_W{1'b0}};
    else                       cnt_r <= cnt_r + DIV_W'(1);
  end

  // Control registers, sticky overflow, bus read data and irq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_r   <= 1'b0;
      irq_en_r   <= 1'b0;
      div_r      <= {DIV_W{1'b0}};
      overflow_r <= 1'b0;
      readdata_r <= {DW{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        enable_r <= writedata[CTRL_ENABLE];
        irq_en_r <= writedata[CTRL_IRQ_EN];
      end
      if (div_wr_s) div_r <= writedata[DIV_W-1:0];
      if (flush_s)                                    overflow_r <= 1'b0;
      else if (sample_s && fifo_full_s && !pop_s)     overflow_r <= 1'b1;
      if (read) readdata_r <= rd_mux_s;
      irq_r <= irq_en_r && (fifo_level_s != {LW{1'b0}});
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_soc_system_signal_sampler.sv
// Directed bench for the signal sampler; read results are queued at issue
// time from a small FIFO/divider model and compared one cycle later.
module tb_soc_system_signal_sampler;
  import soc_system_signal_sampler_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = 2'd0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] writedata = 32'h0;
  logic [DW-1:0] readdata;
  logic [DW-1:0] in_port = 32'h0;
  logic          irq;

  soc_system_signal_sampler #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] in_val = 32'h5A00_0000;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  logic [31:0] m_fifo[$];
  logic        m_en = 1'b0;
  logic [15:0] m_div = 16'h0;
  logic [15:0] m_cnt = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_en  = 1'b0;
    m_div = 16'h0;
    m_cnt = 16'h0;
  endtask

  // One bus cycle: queue expectation, advance model, clock, compare.
  task automatic step(input logic rd, input logic wr, input logic [1:0] a,
                      input logic [31:0] wd, input logic use_model,
                      input logic [31:0] exp, input string tag);
    logic smp, pop, flush;
    logic [31:0] head;
    address = a; read = rd; write = wr; writedata = wd; in_port = in_val;
    head = (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
    if (rd) begin
      exp_q.push_back(use_model ? head : exp);
      tag_q.push_back(tag);
    end
    smp   = m_en && (m_cnt == m_div);
    pop   = rd && (a == ADDR_DATA) && (m_fifo.size() > 0);
    flush = wr && (a == ADDR_CONTROL) && wd[2];
    if (pop) void'(m_fifo.pop_front());
    if (flush) m_fifo.delete();
    else if (smp && m_fifo.size() < DEPTH) m_fifo.push_back(in_val);
    if (wr && a == ADDR_DIVIDER) m_cnt = 16'h0;
    else if (!m_en || smp)       m_cnt = 16'h0;
    else                         m_cnt = m_cnt + 16'd1;
    if (wr && a == ADDR_CONTROL) m_en = wd[0];
    if (wr && a == ADDR_DIVIDER) m_div = wd[15:0];
    @(posedge clk); #1;
    if (rd) chk(tag_q.pop_front(), readdata, exp_q.pop_front());
    read = 1'b0; write = 1'b0;
    cyc++;
    in_val = 32'h5A00_0000 + 32'(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, ADDR_DATA, 32'h0, 1'b0, 32'h0, "idle");
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, 32'h0, "wr");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
    step(1'b1, 1'b0, a, 32'h0, 1'b0, e, tag);
  endtask

  task automatic rd_data(input string tag);
    step(1'b1, 1'b0, ADDR_DATA, 32'h0, 1'b1, 32'h0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rd(ADDR_STATUS, 32'h100, "rst_status");
    rd(ADDR_CONTROL, 32'h0, "rst_control");
    rd(ADDR_DIVIDER, 32'h0, "rst_divider");
    rd(ADDR_DATA, 32'h0, "rst_data_empty");
    wr(ADDR_DATA, 32'hFFFF_FFFF);
    wr(ADDR_STATUS, 32'hFFFF_FFFF);
    rd(ADDR_STATUS, 32'h100, "ro_write_ignored");
    wr(ADDR_DIVIDER, 32'hFFFF_0003);
    rd(ADDR_DIVIDER, 32'h3, "div_upper_ignored");

    // D=3: pushes land on the 4th, 8th and 12th edge after enabling
    wr(ADDR_CONTROL, 32'h1);
    idle(3);
    rd(ADDR_STATUS, 32'h100, "d3_before_p1");
    rd(ADDR_STATUS, 32'h001, "d3_level1");
    idle(2);
    rd(ADDR_STATUS, 32'h001, "d3_before_p2");
    rd(ADDR_STATUS, 32'h002, "d3_level2");
    idle(2);
    rd(ADDR_STATUS, 32'h002, "d3_before_p3");
    rd(ADDR_STATUS, 32'h003, "d3_level3");
    wr(ADDR_CONTROL, 32'h0);
    chk("irq_masked", 32'(irq), 32'h0);
    rd(ADDR_CONTROL, 32'h0, "ctrl_disabled");
    for (int i = 0; i < 3; i++) rd_data("d3_data");
    rd(ADDR_DATA, 32'h0, "d3_drained");

    // irq follows level one cycle late
    wr(ADDR_DIVIDER, 32'h0);
    wr(ADDR_CONTROL, 32'h3);
    wr(ADDR_CONTROL, 32'h2);
    chk("irq_lag", 32'(irq), 32'h0);
    idle(1);
    chk("irq_set", 32'(irq), 32'h1);
    rd_data("irq_data");
    chk("irq_hold", 32'(irq), 32'h1);
    idle(1);
    chk("irq_clear", 32'(irq), 32'h0);

    // D=0 for 10 cycles overfills the FIFO
    wr(ADDR_CONTROL, 32'h1);
    idle(9);
    wr(ADDR_CONTROL, 32'h0);
    rd(ADDR_STATUS, 32'h608, "ovf_status");
    for (int i = 0; i < DEPTH; i++) rd_data("ovf_data");
    rd(ADDR_DATA, 32'h0, "ovf_empty_data");
    rd(ADDR_STATUS, 32'h500, "ovf_sticky");

    // full FIFO with continuous DATA reads never overflows
    wr(ADDR_CONTROL, 32'h4);
    rd(ADDR_STATUS, 32'h100, "flush_clears_ovf");
    wr(ADDR_CONTROL, 32'h1);
    idle(8);
    for (int i = 0; i < 6; i++) rd_data("full_rw_data");
    rd(ADDR_STATUS, 32'h208, "full_rw_status");
    wr(ADDR_CONTROL, 32'h4);
    rd(ADDR_STATUS, 32'h100, "flush_full");

    // DATA read coincident with push into empty FIFO
    wr(ADDR_CONTROL, 32'h1);
    in_val = 32'hA5A5_A5A5;
    rd(ADDR_DATA, 32'h0, "coinc_zero");
    wr(ADDR_CONTROL, 32'h0);
    rd(ADDR_DATA, 32'hA5A5_A5A5, "coinc_next");
    rd_data("coinc_tail");
    rd(ADDR_STATUS, 32'h100, "coinc_empty");

    // flush beats same-cycle push, enable/irq_en retained
    wr(ADDR_CONTROL, 32'h3);
    idle(5);
    wr(ADDR_CONTROL, 32'h7);
    rd(ADDR_STATUS, 32'h100, "flush_vs_push");
    rd(ADDR_CONTROL, 32'h3, "flush_keeps_ctrl");
    wr(ADDR_CONTROL, 32'h4);
    rd(ADDR_STATUS, 32'h100, "flush_off");

    // DIVIDER write restarts the counter
    wr(ADDR_DIVIDER, 32'h2);
    wr(ADDR_CONTROL, 32'h1);
    idle(1);
    wr(ADDR_DIVIDER, 32'h2);
    idle(2);
    rd(ADDR_STATUS, 32'h100, "divw_restart");
    rd(ADDR_STATUS, 32'h001, "divw_push");

    // asynchronous reset mid-operation
    rd(ADDR_CONTROL, 32'h1, "pre_reset_ctrl");
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_readdata", readdata, 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    rd(ADDR_DATA, 32'h0, "post_rst_data");
    rd(ADDR_STATUS, 32'h100, "post_rst_status");
    rd(ADDR_DIVIDER, 32'h0, "post_rst_divider");
    rd(ADDR_CONTROL, 32'h0, "post_rst_control");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
